// File: rtl/axi_single_beat_initiator.sv
// Single-outstanding AXI initiator: turns one host command into one single-beat
// AXI write or read and hands the captured response back to the host.
module axi_single_beat_initiator #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  dut_clock,
    input  logic                  dut_reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_W-1:0]     aw_addr,
    output logic                  aw_valid,
    input  logic                  aw_ready,
    output logic [DATA_W-1:0]     w_data,
    output logic [DATA_W/8-1:0]   w_strb,
    output logic                  w_valid,
    input  logic                  w_ready,
    input  logic [1:0]            b_resp,
    input  logic                  b_valid,
    output logic                  b_ready,
    output logic [ADDR_W-1:0]     ar_addr,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    input  logic [DATA_W-1:0]     r_data,
    input  logic [1:0]            r_resp,
    input  logic                  r_valid,
    output logic                  r_ready
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_t;

    state_t              state_reg, state_next;
    logic                cmd_ready_reg, cmd_ready_next;
    logic                aw_valid_reg, aw_valid_next;
    logic                w_valid_reg, w_valid_next;
    logic                b_ready_reg, b_ready_next;
    logic                ar_valid_reg, ar_valid_next;
    logic                r_ready_reg, r_ready_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic                aw_done_reg, aw_done_next;
    logic                w_done_reg, w_done_next;
    logic [ADDR_W-1:0]   aw_addr_reg, aw_addr_next;
    logic [ADDR_W-1:0]   ar_addr_reg, ar_addr_next;
    logic [DATA_W-1:0]   w_data_reg, w_data_next;
    logic [STRB_W-1:0]   w_strb_reg, w_strb_next;
    logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]          rsp_resp_reg, rsp_resp_next;
    logic                aw_done_now, w_done_now;

    always_ff @(posedge dut_clock or negedge dut_reset_n) begin
        if (!dut_reset_n) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b0;
            aw_valid_reg  <= 1'b0;
            w_valid_reg   <= 1'b0;
            b_ready_reg   <= 1'b0;
            ar_valid_reg  <= 1'b0;
            r_ready_reg   <= 1'b0;
            rsp_valid_reg <= 1'b0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            aw_addr_reg   <= '0;
            ar_addr_reg   <= '0;
            w_data_reg    <= '0;
            w_strb_reg    <= '0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= cmd_ready_next;
            aw_valid_reg  <= aw_valid_next;
            w_valid_reg   <= w_valid_next;
            b_ready_reg   <= b_ready_next;
            ar_valid_reg  <= ar_valid_next;
            r_ready_reg   <= r_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            aw_done_reg   <= aw_done_next;
            w_done_reg    <= w_done_next;
            aw_addr_reg   <= aw_addr_next;
            ar_addr_reg   <= ar_addr_next;
            w_data_reg    <= w_data_next;
            w_strb_reg    <= w_strb_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_resp_reg  <= rsp_resp_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cmd_ready_next = cmd_ready_reg;
        aw_valid_next  = aw_valid_reg;
        w_valid_next   = w_valid_reg;
        b_ready_next   = b_ready_reg;
        ar_valid_next  = ar_valid_reg;
        r_ready_next   = r_ready_reg;
        rsp_valid_next = rsp_valid_reg;
        aw_done_next   = aw_done_reg;
        w_done_next    = w_done_reg;
        aw_addr_next   = aw_addr_reg;
        ar_addr_next   = ar_addr_reg;
        w_data_next    = w_data_reg;
        w_strb_next    = w_strb_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_resp_next  = rsp_resp_reg;
        aw_done_now    = 1'b0;
        w_done_now     = 1'b0;

        case (state_reg)
            IDLE: begin
                // cmd_ready comes up one edge after reset release and stays up while idle
                cmd_ready_next = 1'b1;
                if (cmd_valid && cmd_ready_reg) begin
                    cmd_ready_next = 1'b0;
                    if (cmd_write) begin
                        state_next    = WR_AW_W;
                        aw_valid_next = 1'b1;
                        w_valid_next  = 1'b1;
                        aw_addr_next  = cmd_addr;
                        w_data_next   = cmd_wdata;
                        w_strb_next   = cmd_strb;
                        aw_done_next  = 1'b0;
                        w_done_next   = 1'b0;
                    end else begin
                        state_next    = RD_AR;
                        ar_valid_next = 1'b1;
                        ar_addr_next  = cmd_addr;
                    end
                end
            end
            WR_AW_W: begin
                // AW and W complete independently, in either order or together
                aw_done_now = aw_done_reg || (aw_valid_reg && aw_ready);
                w_done_now  = w_done_reg || (w_valid_reg && w_ready);
                if (aw_valid_reg && aw_ready) begin
                    aw_valid_next = 1'b0;
                end
                if (w_valid_reg && w_ready) begin
                    w_valid_next = 1'b0;
                end
                if (aw_done_now && w_done_now) begin
                    state_next   = WR_B;
                    b_ready_next = 1'b1;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end else begin
                    aw_done_next = aw_done_now;
                    w_done_next  = w_done_now;
                end
            end
            WR_B: begin
                if (b_valid && b_ready_reg) begin
                    b_ready_next   = 1'b0;
                    rsp_resp_next  = b_resp;
                    rsp_rdata_next = '0;
                    state_next     = RSP;
                end
            end
            RD_AR: begin
                if (ar_valid_reg && ar_ready) begin
                    ar_valid_next = 1'b0;
                    r_ready_next  = 1'b1;
                    state_next    = RD_R;
                end
            end
            RD_R: begin
                if (r_valid && r_ready_reg) begin
                    r_ready_next   = 1'b0;
                    rsp_rdata_next = r_data;
                    rsp_resp_next  = r_resp;
                    state_next     = RSP;
                end
            end
            RSP: begin
                // rsp_valid is a registered Moore output, so it rises one edge after entry
                rsp_valid_next = 1'b1;
                if (rsp_valid_reg && rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    cmd_ready_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd_ready = cmd_ready_reg;
    assign aw_valid  = aw_valid_reg;
    assign aw_addr   = aw_addr_reg;
    assign w_valid   = w_valid_reg;
    assign w_data    = w_data_reg;
    assign w_strb    = w_strb_reg;
    assign b_ready   = b_ready_reg;
    assign ar_valid  = ar_valid_reg;
    assign ar_addr   = ar_addr_reg;
    assign r_ready   = r_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_resp  = rsp_resp_reg;

endmodule
